// File: rtl/zet_isa8_bridge.sv
// Wishbone slave that turns each 16-bit Zet CPU access into one or two
// 8-bit PC-bus cycles (ALE/address, command strobe stretched by IOCHRDY).
module zet_isa8_bridge #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned CMD_CYC   = 3,
  parameter int unsigned TO_CYC    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [19:1] wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_tga_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [19:0] isa_adr_o,
  output logic        isa_ale_o,
  output logic [7:0]  isa_dat_o,
  output logic        isa_dat_oe_o,
  input  logic [7:0]  isa_dat_i,
  output logic        isa_memr_no,
  output logic        isa_memw_no,
  output logic        isa_ior_no,
  output logic        isa_iow_no,
  input  logic        isa_iochrdy_i,
  output logic        bus_timeout_o
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CMD_LAST   = 4'(CMD_CYC - 1);
  localparam logic [7:0] TO_LIMIT   = 8'(TO_CYC);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [7:0]  wait_cnt;
  logic        we_q, tga_q, odd_pend, aborted;
  logic [1:0]  sel_q;
  logic [15:0] dat_q;

  logic req, accept, setup_done, cmd_last, sample, timeout_hit, finish, next_byte;
  logic [7:0] rd_byte;

  always_comb begin
    req         = wb_stb_i & wb_cyc_i;
    accept      = (state == IDLE) & req & ~wb_ack_o;
    setup_done  = (cnt == SETUP_LAST);
    cmd_last    = (cnt == CMD_LAST);
    sample      = (state == STROBE) & cmd_last;
    timeout_hit = sample & ~isa_iochrdy_i & (wait_cnt == TO_LIMIT);
    finish      = sample & (isa_iochrdy_i | timeout_hit);
    next_byte   = (state == HOLD) & odd_pend & ~aborted & req;
    rd_byte     = timeout_hit ? 8'hFF : isa_dat_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (wb_sel_i == 2'b00) ? ACK : SETUP;
      SETUP:   if (setup_done) state_nx = STROBE;
      STROBE:  if (finish) state_nx = HOLD;
      // A master that let go at any point after acceptance gets no ack.
      HOLD:    if (aborted | ~req) state_nx = IDLE;
               else if (odd_pend)  state_nx = SETUP;
               else                state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o     = (state == ACK);
    isa_ale_o    = (state == SETUP);
    isa_dat_oe_o = we_q & ((state == SETUP) | (state == STROBE) | (state == HOLD));
    isa_memr_no  = ~((state == STROBE) & ~tga_q & ~we_q);
    isa_memw_no  = ~((state == STROBE) & ~tga_q &  we_q);
    isa_ior_no   = ~((state == STROBE) &  tga_q & ~we_q);
    isa_iow_no   = ~((state == STROBE) &  tga_q &  we_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt           <= '0;
      wait_cnt      <= '0;
      we_q          <= 1'b0;
      tga_q         <= 1'b0;
      sel_q         <= '0;
      dat_q         <= '0;
      odd_pend      <= 1'b0;
      aborted       <= 1'b0;
      isa_adr_o     <= '0;
      isa_dat_o     <= '0;
      wb_dat_o      <= '0;
      bus_timeout_o <= 1'b0;
    end else begin
      bus_timeout_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          we_q      <= wb_we_i;
          tga_q     <= wb_tga_i;
          sel_q     <= wb_sel_i;
          dat_q     <= wb_dat_i;
          cnt       <= '0;
          wait_cnt  <= '0;
          aborted   <= 1'b0;
          odd_pend  <= (wb_sel_i == 2'b11);
          isa_adr_o <= {wb_adr_i, wb_sel_i == 2'b10};
          isa_dat_o <= (wb_sel_i == 2'b10) ? wb_dat_i[15:8] : wb_dat_i[7:0];
          if (wb_sel_i == 2'b00) wb_dat_o <= '0;
        end
        SETUP: begin
          cnt <= setup_done ? '0 : cnt + 4'd1;
          if (!req) aborted <= 1'b1;
        end
        STROBE: begin
          if (!req) aborted <= 1'b1;
          if (!cmd_last)    cnt      <= cnt + 4'd1;
          else if (!finish) wait_cnt <= wait_cnt + 8'd1;
          if (finish) begin
            cnt           <= '0;
            wait_cnt      <= '0;
            bus_timeout_o <= timeout_hit;
            // The first captured byte clears the other lane; the odd byte of
            // a word keeps the even byte captured just before it.
            if (!we_q) begin
              if (isa_adr_o[0])
                wb_dat_o <= {rd_byte, (sel_q == 2'b11) ? wb_dat_o[7:0] : 8'h00};
              else
                wb_dat_o <= {8'h00, rd_byte};
            end
          end
        end
        HOLD: if (next_byte) begin
          odd_pend     <= 1'b0;
          isa_adr_o[0] <= 1'b1;
          isa_dat_o    <= dat_q[15:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zet_isa8_bridge.sv
// Directed self-checking bench for zet_isa8_bridge: a negedge bus monitor logs
// command runs while per-scenario tasks compare against hand-computed values.
module tb_zet_isa8_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic [19:1] wb_adr_i = '0;
  logic        wb_we_i = 1'b0, wb_tga_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_ack_o;
  logic [19:0] isa_adr_o;
  logic        isa_ale_o, isa_dat_oe_o;
  logic [7:0]  isa_dat_o, isa_dat_i;
  logic        isa_memr_no, isa_memw_no, isa_ior_no, isa_iow_no;
  logic        rdy = 1'b1;
  logic        bus_timeout_o;
  logic [7:0]  rd_lo = 8'h00, rd_hi = 8'h00;

  int n_vec = 0, n_fail = 0;

  zet_isa8_bridge #(.SETUP_CYC(1), .CMD_CYC(3), .TO_CYC(255)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_tga_i(wb_tga_i), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .isa_adr_o(isa_adr_o), .isa_ale_o(isa_ale_o), .isa_dat_o(isa_dat_o),
    .isa_dat_oe_o(isa_dat_oe_o), .isa_dat_i(isa_dat_i),
    .isa_memr_no(isa_memr_no), .isa_memw_no(isa_memw_no),
    .isa_ior_no(isa_ior_no), .isa_iow_no(isa_iow_no),
    .isa_iochrdy_i(rdy), .bus_timeout_o(bus_timeout_o)
  );

  always #5 clk = ~clk;

  assign isa_dat_i = isa_adr_o[0] ? rd_hi : rd_lo;

  // Monitor state: written only by the negedge block below.
  int         clr_gen = 0, seen_gen = 0, wait_req = 0;
  int         run_len = 0, n_runs = 0, ale_cycles = 0, to_pulses = 0, ack_cnt = 0, viol = 0;
  logic [3:0] run_kind [4];
  logic [19:0] run_adr [4];
  logic [7:0] run_dat [4];
  logic       run_oe [4], hold_oe [4];
  int         run_length [4];
  logic [3:0] cmd_low;

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      n_runs = 0; ale_cycles = 0; to_pulses = 0; ack_cnt = 0; viol = 0;
      for (int i = 0; i < 4; i++) begin
        run_kind[i] = '0; run_adr[i] = '0; run_dat[i] = '0;
        run_oe[i] = 1'b0; hold_oe[i] = 1'b0; run_length[i] = 0;
      end
    end
    cmd_low = {~isa_memr_no, ~isa_memw_no, ~isa_ior_no, ~isa_iow_no};
    if ($countones(cmd_low) > 1 || (cmd_low != 4'b0 && isa_ale_o)) viol++;
    if (isa_ale_o) ale_cycles++;
    if (bus_timeout_o) to_pulses++;
    if (wb_ack_o) ack_cnt++;
    if (cmd_low != 4'b0) begin
      if (run_len == 0 && n_runs < 4) begin
        run_kind[n_runs] = cmd_low; run_adr[n_runs] = isa_adr_o;
        run_dat[n_runs] = isa_dat_o; run_oe[n_runs] = isa_dat_oe_o;
      end
      run_len++;
      rdy = !(run_len >= 3 && run_len < 3 + wait_req);
    end else begin
      if (run_len != 0) begin
        if (n_runs < 4) begin
          run_length[n_runs] = run_len;
          hold_oe[n_runs] = isa_dat_oe_o;
        end
        n_runs++;
      end
      run_len = 0;
      rdy = 1'b1;
    end
  end

  task automatic clear_mon(input int wreq);
    wait_req = wreq;
    clr_gen++;
  endtask

  // Entered and left at #1 after a rising edge; lat = ack position relative to
  // the acceptance edge k (ack sampled at edge k+lat), 0 if the budget expires.
  task automatic run_txn(input logic [18:0] adr, input logic we, input logic tga,
                         input logic [1:0] sel, input logic [15:0] dat,
                         input int wreq, output int lat);
    clear_mon(wreq);
    wb_adr_i = adr; wb_we_i = we; wb_tga_i = tga; wb_sel_i = sel; wb_dat_i = dat;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 400; n++) begin
      #1;
      if (wb_ack_o) begin lat = n; break; end
      @(posedge clk);
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_vec++; if ({isa_memr_no, isa_memw_no, isa_ior_no, isa_iow_no} !== 4'hF) begin n_fail++; $display("FAIL reset_cmds got %b exp 1111", {isa_memr_no, isa_memw_no, isa_ior_no, isa_iow_no}); end
    n_vec++; if ({isa_ale_o, isa_dat_oe_o, wb_ack_o, bus_timeout_o} !== 4'h0) begin n_fail++; $display("FAIL reset_ctl got %b exp 0000", {isa_ale_o, isa_dat_oe_o, wb_ack_o, bus_timeout_o}); end
    n_vec++; if ({isa_adr_o, isa_dat_o, wb_dat_o} !== 44'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {isa_adr_o, isa_dat_o, wb_dat_o}); end
  endtask

  task automatic test_mem_word_read;
    int lat;
    rd_lo = 8'hAB; rd_hi = 8'hCD;
    run_txn(19'h12345, 1'b0, 1'b0, 2'b11, 16'h0000, 0, lat);
    n_vec++; if (lat !== 11) begin n_fail++; $display("FAIL word_rd_latency got %0d exp 11", lat); end
    n_vec++; if (n_runs !== 2) begin n_fail++; $display("FAIL word_rd_runs got %0d exp 2", n_runs); end
    n_vec++; if (run_adr[0] !== 20'h2468A) begin n_fail++; $display("FAIL word_rd_adr0 got %h exp 2468a", run_adr[0]); end
    n_vec++; if (run_adr[1] !== 20'h2468B) begin n_fail++; $display("FAIL word_rd_adr1 got %h exp 2468b", run_adr[1]); end
    n_vec++; if (run_length[0] !== 3 || run_length[1] !== 3) begin n_fail++; $display("FAIL word_rd_width got %0d/%0d exp 3/3", run_length[0], run_length[1]); end
    n_vec++; if (run_kind[0] !== 4'b1000 || run_kind[1] !== 4'b1000) begin n_fail++; $display("FAIL word_rd_cmd got %b/%b exp 1000", run_kind[0], run_kind[1]); end
    n_vec++; if (wb_dat_o !== 16'hCDAB) begin n_fail++; $display("FAIL word_rd_data got %h exp cdab", wb_dat_o); end
    n_vec++; if (ale_cycles !== 2 || to_pulses !== 0 || viol !== 0) begin n_fail++; $display("FAIL word_rd_misc got ale=%0d to=%0d viol=%0d exp 2/0/0", ale_cycles, to_pulses, viol); end
  endtask

  task automatic test_io_byte_write;
    int lat;
    run_txn(19'h001B0, 1'b1, 1'b1, 2'b10, 16'h5A00, 0, lat);
    n_vec++; if (lat !== 6) begin n_fail++; $display("FAIL io_wr_latency got %0d exp 6", lat); end
    n_vec++; if (n_runs !== 1 || run_kind[0] !== 4'b0001) begin n_fail++; $display("FAIL io_wr_cmd got runs=%0d kind=%b exp 1/0001", n_runs, run_kind[0]); end
    n_vec++; if (run_adr[0] !== 20'h00361) begin n_fail++; $display("FAIL io_wr_adr got %h exp 00361", run_adr[0]); end
    n_vec++; if (run_dat[0] !== 8'h5A || run_oe[0] !== 1'b1) begin n_fail++; $display("FAIL io_wr_dat got %h oe=%b exp 5a/1", run_dat[0], run_oe[0]); end
    n_vec++; if (hold_oe[0] !== 1'b1) begin n_fail++; $display("FAIL io_wr_hold_oe got %b exp 1", hold_oe[0]); end
    n_vec++; if (wb_dat_o !== 16'hCDAB) begin n_fail++; $display("FAIL io_wr_keeps_rd got %h exp cdab", wb_dat_o); end
  endtask

  task automatic test_wait_states;
    int lat;
    rd_lo = 8'h3C;
    run_txn(19'h00800, 1'b0, 1'b0, 2'b01, 16'h0000, 4, lat);
    n_vec++; if (lat !== 10) begin n_fail++; $display("FAIL wait_latency got %0d exp 10", lat); end
    n_vec++; if (run_length[0] !== 7 || run_kind[0] !== 4'b1000) begin n_fail++; $display("FAIL wait_width got %0d kind=%b exp 7/1000", run_length[0], run_kind[0]); end
    n_vec++; if (wb_dat_o !== 16'h003C) begin n_fail++; $display("FAIL wait_data got %h exp 003c", wb_dat_o); end
  endtask

  task automatic test_timeout;
    int lat;
    rd_lo = 8'h11;
    run_txn(19'h00040, 1'b0, 1'b1, 2'b01, 16'h0000, 1000, lat);
    n_vec++; if (lat !== 261) begin n_fail++; $display("FAIL to_latency got %0d exp 261", lat); end
    n_vec++; if (run_length[0] !== 258 || run_kind[0] !== 4'b0010) begin n_fail++; $display("FAIL to_width got %0d kind=%b exp 258/0010", run_length[0], run_kind[0]); end
    n_vec++; if (to_pulses !== 1) begin n_fail++; $display("FAIL to_pulse got %0d exp 1", to_pulses); end
    n_vec++; if (wb_dat_o !== 16'h00FF) begin n_fail++; $display("FAIL to_data got %h exp 00ff", wb_dat_o); end
  endtask

  task automatic test_reset_midcycle;
    int lat;
    bit seen = 0;
    clear_mon(0);
    wb_adr_i = 19'h00300; wb_we_i = 1'b1; wb_tga_i = 1'b0; wb_sel_i = 2'b01; wb_dat_i = 16'h0099;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (!isa_memw_no) seen = 1;
    end
    n_vec++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_memw_seen got %b exp 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (isa_memw_no !== 1'b1 || wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_async got memw_n=%b ack=%b exp 1/0", isa_memw_no, wb_ack_o); end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ack_cnt !== 0) begin n_fail++; $display("FAIL rst_no_ack got %0d exp 0", ack_cnt); end
    run_txn(19'h00300, 1'b1, 1'b0, 2'b01, 16'h0077, 0, lat);
    n_vec++; if (lat !== 6 || n_runs !== 1 || run_kind[0] !== 4'b0100 || run_dat[0] !== 8'h77) begin n_fail++; $display("FAIL rst_recover got lat=%0d runs=%0d kind=%b dat=%h exp 6/1/0100/77", lat, n_runs, run_kind[0], run_dat[0]); end
  endtask

  task automatic test_sel_none;
    int lat;
    run_txn(19'h00010, 1'b0, 1'b0, 2'b00, 16'h0000, 0, lat);
    n_vec++; if (lat !== 1) begin n_fail++; $display("FAIL sel00_latency got %0d exp 1", lat); end
    n_vec++; if (n_runs !== 0 || ale_cycles !== 0) begin n_fail++; $display("FAIL sel00_bus got runs=%0d ale=%0d exp 0/0", n_runs, ale_cycles); end
    n_vec++; if (wb_dat_o !== 16'h0000) begin n_fail++; $display("FAIL sel00_data got %h exp 0000", wb_dat_o); end
  endtask

  task automatic test_abort;
    int lat;
    bit seen = 0;
    clear_mon(0);
    wb_adr_i = 19'h00500; wb_we_i = 1'b0; wb_tga_i = 1'b0; wb_sel_i = 2'b11;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (!isa_memr_no) seen = 1;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_sel_i = '0;
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (n_runs !== 1 || ale_cycles !== 1) begin n_fail++; $display("FAIL abort_runs got runs=%0d ale=%0d exp 1/1", n_runs, ale_cycles); end
    n_vec++; if (ack_cnt !== 0) begin n_fail++; $display("FAIL abort_no_ack got %0d exp 0", ack_cnt); end
    run_txn(19'h00010, 1'b0, 1'b0, 2'b00, 16'h0000, 0, lat);
    n_vec++; if (lat !== 1) begin n_fail++; $display("FAIL abort_idle got lat=%0d exp 1", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_txn(19'h00100, 1'b1, 1'b0, 2'b11, 16'h1234, 0, lat);
    n_vec++; if (lat !== 11 || n_runs !== 2) begin n_fail++; $display("FAIL b2b_wr got lat=%0d runs=%0d exp 11/2", lat, n_runs); end
    n_vec++; if (run_adr[0] !== 20'h00200 || run_adr[1] !== 20'h00201) begin n_fail++; $display("FAIL b2b_wr_adr got %h/%h exp 00200/00201", run_adr[0], run_adr[1]); end
    n_vec++; if (run_dat[0] !== 8'h34 || run_dat[1] !== 8'h12 || run_kind[1] !== 4'b0100) begin n_fail++; $display("FAIL b2b_wr_dat got %h/%h kind=%b exp 34/12/0100", run_dat[0], run_dat[1], run_kind[1]); end
    rd_hi = 8'h77;
    run_txn(19'h00100, 1'b0, 1'b0, 2'b10, 16'h0000, 0, lat);
    n_vec++; if (lat !== 6 || run_adr[0] !== 20'h00201) begin n_fail++; $display("FAIL b2b_rd got lat=%0d adr=%h exp 6/00201", lat, run_adr[0]); end
    n_vec++; if (wb_dat_o !== 16'h7700 || viol !== 0) begin n_fail++; $display("FAIL b2b_rd_data got %h viol=%0d exp 7700/0", wb_dat_o, viol); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_mem_word_read;
    test_io_byte_write;
    test_wait_states;
    test_timeout;
    test_reset_midcycle;
    test_sel_none;
    test_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
